dport_regs: RTL and testbench

- Control/status register bank for the DisplayPort output path. Sits directly downstream of the AXI3-to-simple-bus bridge and consumes its out* request interface (addr/wdata/wstrb/wr/req, returns ack/rdata/err).
- Holds link enable, video timing configuration, the hot-plug and vsync interrupt logic, and a frame counter. Those values drive the video timing generator and the link controller.

---
 rtl/dport_regs_pkg.sv | 46 ++++
 rtl/dport_regs_if.sv | 26 ++
 rtl/dport_regs_sync2.sv | 23 ++
 rtl/dport_regs.sv | 142 ++++++++++++++
 tb/tb_dport_regs.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dport_regs_pkg.sv
// dport_regs_pkg: shared definitions for the DisplayPort control/status
// register bank. Holds register word offsets (addr[7:2]), CTRL/IRQ bit
// positions, bus response codes shared with the bridge, the access FSM
// state type and the byte-lane merge helper.
package dport_regs_pkg;

  // Word offsets, compared against addr[7:2]
  localparam logic [5:0] REG_CTRL     = 6'h00;
  localparam logic [5:0] REG_STATUS   = 6'h01;
  localparam logic [5:0] REG_IRQ      = 6'h02;
  localparam logic [5:0] REG_HTIMING  = 6'h03;
  localparam logic [5:0] REG_VTIMING  = 6'h04;
  localparam logic [5:0] REG_FRAMECNT = 6'h05;
  localparam logic [5:0] REG_SCRATCH  = 6'h06;

  // CTRL bit positions
  localparam int unsigned CTRL_EN       = 0;
  localparam int unsigned CTRL_VSYNC_IE = 1;
  localparam int unsigned CTRL_HPD_IE   = 2;

  // IRQ bit positions
  localparam int unsigned IRQ_VSYNC = 0;
  localparam int unsigned IRQ_HPD   = 1;

  // Response codes carried on err
  localparam logic RESP_OKAY   = 1'b0;
  localparam logic RESP_SLVERR = 1'b1;

  typedef enum logic {
    ST_IDLE,
    ST_RESP
  } state_t;

  // Replace only the bytes whose strobe bit is set
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int unsigned b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dport_regs_if.sv
// dport_regs_if: simple request bus between the AXI3 bridge (master) and
// the register bank (slave).
//   addr/wdata/wstrb/wr/req : master -> slave request, req held until ack
//   ack/rdata/err           : slave -> master one-cycle completion
interface dport_regs_if #(
  parameter int unsigned ADDR = 32
);
  logic [ADDR-1:0] addr;
  logic [31:0]     wdata;
  logic [3:0]      wstrb;
  logic            wr;
  logic            req;
  logic            ack;
  logic [31:0]     rdata;
  logic            err;

  modport master (
    output addr, wdata, wstrb, wr, req,
    input  ack, rdata, err
  );

  modport slave (
    input  addr, wdata, wstrb, wr, req,
    output ack, rdata, err
  );
endinterface

// File: rtl/dport_regs_sync2.sv
// sync2: two-flop synchronizer for an asynchronous level input.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, both flops clear to 0
//   d     : asynchronous input
//   q     : synchronized output (2 cycles latency)
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/dport_regs.sv
// dport_regs: DisplayPort output path control/status register bank.
//   clk, resetn          : clock, asynchronous active-low reset
//   bus (slave)          : addr/wdata/wstrb/wr/req in, ack/rdata/err out
//   hpd, link_ok         : asynchronous status pins (synchronized here)
//   vsync                : one-cycle start-of-frame pulse, clk domain
//   enable               : CTRL[0]
//   hactive/htotal       : HTIMING[15:0]/[31:16]
//   vactive/vtotal       : VTIMING[15:0]/[31:16]
//   irq                  : registered interrupt line
module dport_regs
  import dport_regs_pkg::*;
#(
  parameter int unsigned ADDR        = 32,
  parameter logic [15:0] HACTIVE_RST = 16'd640,
  parameter logic [15:0] HTOTAL_RST  = 16'd800,
  parameter logic [15:0] VACTIVE_RST = 16'd480,
  parameter logic [15:0] VTOTAL_RST  = 16'd525
) (
  input  logic           clk,
  input  logic           resetn,
  dport_regs_if.slave    bus,
  input  logic           hpd,
  input  logic           link_ok,
  input  logic           vsync,
  output logic           enable,
  output logic [15:0]    hactive,
  output logic [15:0]    htotal,
  output logic [15:0]    vactive,
  output logic [15:0]    vtotal,
  output logic           irq
);

  state_t      state, state_nxt;
  logic [2:0]  ctrl;
  logic [1:0]  irq_st;
  logic [31:0] htiming;
  logic [31:0] vtiming;
  logic [31:0] framecnt;
  logic [31:0] scratch;

  logic        hpd_s, hpd_d, link_ok_s;
  logic        take, mapped, wr_en;
  logic [5:0]  idx;
  logic [31:0] rd_val;
  logic        vs_evt, hpd_evt;
  logic [1:0]  irq_clr, irq_set;

  // addr[1:0] is deliberately ignored by the decode
  logic        unused_addr_lsb;
  assign unused_addr_lsb = ^bus.addr[1:0];

  sync2 u_sync_hpd  (.clk(clk), .rst_n(resetn), .d(hpd),     .q(hpd_s));
  sync2 u_sync_link (.clk(clk), .rst_n(resetn), .d(link_ok), .q(link_ok_s));

  // Access FSM
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.req) begin
          take      = 1'b1;
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Decode
  assign idx    = bus.addr[7:2];
  assign mapped = (bus.addr[ADDR-1:8] == '0) && (idx <= REG_SCRATCH);
  assign wr_en  = take && bus.wr && mapped;

  always_comb begin
    rd_val = '0;
    case (idx)
      REG_CTRL:     rd_val = {29'd0, ctrl};
      REG_STATUS:   rd_val = {29'd0, ctrl[CTRL_EN], link_ok_s, hpd_s};
      REG_IRQ:      rd_val = {30'd0, irq_st};
      REG_HTIMING:  rd_val = htiming;
      REG_VTIMING:  rd_val = vtiming;
      REG_FRAMECNT: rd_val = framecnt;
      REG_SCRATCH:  rd_val = scratch;
      default:      rd_val = '0;
    endcase
  end

  // Events; a same-cycle set overrides the w1c clear
  assign vs_evt  = vsync && ctrl[CTRL_EN];
  assign hpd_evt = hpd_s ^ hpd_d;
  assign irq_set = {hpd_evt, vs_evt};
  assign irq_clr = (wr_en && idx == REG_IRQ && bus.wstrb[0]) ? bus.wdata[1:0] : 2'b00;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.ack   <= 1'b0;
      bus.err   <= RESP_OKAY;
      bus.rdata <= '0;
      ctrl      <= '0;
      irq_st    <= '0;
      htiming   <= {HTOTAL_RST, HACTIVE_RST};
      vtiming   <= {VTOTAL_RST, VACTIVE_RST};
      framecnt  <= '0;
      scratch   <= '0;
      hpd_d     <= 1'b0;
      irq       <= 1'b0;
    end else begin
      bus.ack   <= take;
      bus.err   <= (take && !mapped) ? RESP_SLVERR : RESP_OKAY;
      bus.rdata <= (take && mapped && !bus.wr) ? rd_val : '0;

      if (wr_en) begin
        case (idx)
          REG_CTRL:    if (bus.wstrb[0]) ctrl <= bus.wdata[2:0];
          REG_HTIMING: htiming <= apply_wstrb(htiming, bus.wdata, bus.wstrb);
          REG_VTIMING: vtiming <= apply_wstrb(vtiming, bus.wdata, bus.wstrb);
          REG_SCRATCH: scratch <= apply_wstrb(scratch, bus.wdata, bus.wstrb);
          default: ;
        endcase
      end

      irq_st   <= (irq_st & ~irq_clr) | irq_set;
      framecnt <= framecnt + {31'd0, vs_evt};
      hpd_d    <= hpd_s;
      irq      <= |(irq_st & ctrl[CTRL_HPD_IE:CTRL_VSYNC_IE]);
    end
  end

  assign enable  = ctrl[CTRL_EN];
  assign hactive = htiming[15:0];
  assign htotal  = htiming[31:16];
  assign vactive = vtiming[15:0];
  assign vtotal  = vtiming[31:16];

endmodule

// File: tb/tb_dport_regs.sv
// tb_dport_regs: randomized scoreboard bench for dport_regs. The driver
// computes each expected response from a register-map model and queues it;
// a monitor pops and compares whenever ack is presented.
module tb_dport_regs;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, hpd, link_ok, vsync;
  logic        enable, irq;
  logic [15:0] hactive, htotal, vactive, vtotal;

  dport_regs_if #(.ADDR(32)) bus ();

  dport_regs #(
    .ADDR(32), .HACTIVE_RST(16'd640), .HTOTAL_RST(16'd800),
    .VACTIVE_RST(16'd480), .VTOTAL_RST(16'd525)
  ) dut (
    .clk(clk), .resetn(resetn), .bus(bus), .hpd(hpd), .link_ok(link_ok),
    .vsync(vsync), .enable(enable), .hactive(hactive), .htotal(htotal),
    .vactive(vactive), .vtotal(vtotal), .irq(irq)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    string       name;
  } exp_t;

  exp_t q[$];
  int checks = 0, failures = 0, acks_seen = 0, accesses = 0;

  // Register-map model
  logic [2:0]  m_ctrl;
  logic [1:0]  m_irq;
  logic [31:0] m_fc, m_scr, m_ht, m_vt;
  logic        m_hpd_s, m_link_s;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ctrl = 3'd0; m_irq = 2'd0; m_fc = 32'd0; m_scr = 32'd0;
    m_ht = {16'd800, 16'd640};
    m_vt = {16'd525, 16'd480};
    m_hpd_s = 1'b0; m_link_s = 1'b0;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input int idx);
    case (idx)
      0: return {29'd0, m_ctrl};
      1: return {29'd0, m_ctrl[0], m_link_s, m_hpd_s};
      2: return {30'd0, m_irq};
      3: return m_ht;
      4: return m_vt;
      5: return m_fc;
      6: return m_scr;
      default: return 32'd0;
    endcase
  endfunction

  task automatic check_outs(input string tag);
    chk({tag, "_enable"},  {31'd0, enable},  {31'd0, m_ctrl[0]});
    chk({tag, "_hactive"}, {16'd0, hactive}, {16'd0, m_ht[15:0]});
    chk({tag, "_htotal"},  {16'd0, htotal},  {16'd0, m_ht[31:16]});
    chk({tag, "_vactive"}, {16'd0, vactive}, {16'd0, m_vt[15:0]});
    chk({tag, "_vtotal"},  {16'd0, vtotal},  {16'd0, m_vt[31:16]});
    chk({tag, "_irq"},     {31'd0, irq},     {31'd0, |(m_irq & m_ctrl[2:1])});
  endtask

  // Monitor: every ack must match the oldest queued expectation
  always @(negedge clk) begin
    if (resetn === 1'b1 && bus.ack === 1'b1) begin
      exp_t e;
      acks_seen++;
      if (q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_ack actual=ack expected=no_ack");
      end else begin
        e = q.pop_front();
        chk({e.name, "_rdata"}, bus.rdata, e.rdata);
        chk({e.name, "_err"}, {31'd0, bus.err}, {31'd0, e.err});
      end
    end
  end

  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input bit hold, input bit vs);
    exp_t e;
    bit   ok, got, en_old;
    int   idx;
    ok  = (a[31:8] == 24'd0) && (a[7:2] <= 6'd6);
    idx = int'(a[7:2]);
    e.err   = !ok;
    e.rdata = (ok && !w) ? model_read(idx) : 32'd0;
    e.name  = $sformatf("%s%02h", w ? "wr" : "rd", a[7:0]);
    @(negedge clk);
    bus.req = 1'b1; bus.wr = w; bus.addr = a; bus.wdata = d; bus.wstrb = s;
    vsync = vs;
    q.push_back(e);
    accesses++;
    en_old = m_ctrl[0];
    if (ok && w) begin
      case (idx)
        0: if (s[0]) m_ctrl = d[2:0];
        2: if (s[0]) m_irq = m_irq & ~d[1:0];
        3: m_ht  = merge(m_ht, d, s);
        4: m_vt  = merge(m_vt, d, s);
        6: m_scr = merge(m_scr, d, s);
        default: ;
      endcase
    end
    if (vs && en_old) begin
      m_fc  = m_fc + 32'd1;
      m_irq = m_irq | 2'b01;
    end
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      vsync = 1'b0;
      if (bus.ack === 1'b1) got = 1'b1;
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL ack_timeout_%s actual=no_ack expected=ack", e.name);
      if (q.size() > 0) void'(q.pop_back());
    end
    if (hold) @(negedge clk);
    bus.req = 1'b0; bus.wr = 1'b0;
    @(negedge clk);
    check_outs(e.name);
  endtask

  task automatic rd(input logic [31:0] a, input bit hold = 1'b0);
    access(1'b0, a, $urandom, 4'($urandom), hold, 1'b0);
  endtask

  task automatic wrt(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     input bit vs = 1'b0);
    access(1'b1, a, d, s, 1'b0, vs);
  endtask

  task automatic pulse_vsync();
    @(negedge clk); vsync = 1'b1;
    @(negedge clk); vsync = 1'b0;
    @(negedge clk);
    if (m_ctrl[0]) begin
      m_fc  = m_fc + 32'd1;
      m_irq = m_irq | 2'b01;
    end
    check_outs("vsync");
  endtask

  task automatic set_hpd(input logic v);
    @(negedge clk); hpd = v;
    repeat (4) @(negedge clk);
    if (v != m_hpd_s) m_irq = m_irq | 2'b10;
    m_hpd_s = v;
    check_outs("hpd");
  endtask

  task automatic set_link(input logic v);
    @(negedge clk); link_ok = v;
    repeat (4) @(negedge clk);
    m_link_s = v;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          sel;
    resetn = 1'b0; hpd = 1'b0; link_ok = 1'b1; vsync = 1'b0;
    bus.req = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.wdata = '0; bus.wstrb = '0;
    model_reset();
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    m_link_s = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_ack", {31'd0, bus.ack}, 32'd0);
    check_outs("reset");

    // Timing reset values
    rd(32'h0C); rd(32'h10);

    // Byte strobes, ro write, wstrb=0
    wrt(32'h18, 32'hAABBCCDD, 4'b0101);
    rd(32'h18);
    wrt(32'h14, 32'hFFFFFFFF, 4'hF);
    rd(32'h14);
    wrt(32'h18, 32'h12345678, 4'b0000);
    rd(32'h18);

    // Unmapped addresses, then CTRL still writable
    rd(32'h40); rd(32'h100);
    wrt(32'h0000_0200, 32'h7, 4'hF);
    wrt(32'h00, 32'h3, 4'hF);
    rd(32'h00);

    // vsync counting and interrupt
    repeat (3) pulse_vsync();
    rd(32'h14); rd(32'h08);
    wrt(32'h08, 32'h1, 4'h1);
    rd(32'h08);
    pulse_vsync();
    wrt(32'h08, 32'h1, 4'h1, 1'b1);
    rd(32'h08); rd(32'h14);

    // vsync ignored while disabled
    wrt(32'h00, 32'h2, 4'h1);
    pulse_vsync();
    rd(32'h14);

    // Hot-plug
    wrt(32'h08, 32'h3, 4'hF);
    wrt(32'h00, 32'h5, 4'hF);
    set_hpd(1'b1);
    rd(32'h04); rd(32'h08);
    rd(32'h04, 1'b1);
    wrt(32'h08, 32'h2, 4'h1);
    set_hpd(1'b0);
    set_link(1'b0);
    rd(32'h04, 1'b1);
    rd(32'h08);

    // Randomized traffic
    for (int n = 0; n < 200; n++) begin
      sel = $urandom_range(0, 11);
      if (sel == 0) pulse_vsync();
      else begin
        if (sel <= 8)      a = {24'd0, 6'($urandom_range(0, 6)), 2'($urandom)};
        else if (sel == 9) a = {24'd0, 6'($urandom_range(7, 63)), 2'($urandom)};
        else               a = $urandom | 32'h100;
        access(1'($urandom), a, $urandom, 4'($urandom), 1'($urandom_range(0, 1)),
               $urandom_range(0, 7) == 0);
      end
    end

    // FRAMECNT wrap
    wrt(32'h00, 32'h1, 4'h1);
    @(negedge clk);
    force dut.framecnt = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.framecnt;
    m_fc = 32'hFFFF_FFFF;
    rd(32'h14);
    pulse_vsync();
    rd(32'h14);

    // Reset in the middle of an access
    wrt(32'h18, 32'h55AA55AA, 4'hF);
    wrt(32'h00, 32'h7, 4'hF);
    set_link(1'b1);
    @(negedge clk);
    bus.req = 1'b1; bus.wr = 1'b1; bus.addr = 32'h0C; bus.wdata = 32'h0; bus.wstrb = 4'hF;
    #2 resetn = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_mid_ack", {31'd0, bus.ack}, 32'd0);
    end
    bus.req = 1'b0; bus.wr = 1'b0;
    resetn = 1'b1;
    model_reset();
    m_hpd_s = hpd;
    repeat (3) @(negedge clk);
    m_link_s = 1'b1;
    check_outs("post_rst");
    for (int r = 0; r < 7; r++) rd(32'(r * 4));

    repeat (2) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    chk("ack_count", 32'(acks_seen), 32'(accesses));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
